// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared types and constants for the instruction-memory load controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {RUN, CLEAR, LOAD, WRITE} state_e;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    function automatic int bytes_per_word(input int n);
        return n / 8;
    endfunction

    localparam int BYTES_PER_WORD = bytes_per_word(WORD_W);

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// byte_packer: assembles a little-endian instruction word from a byte stream.
module byte_packer import imem_ctrl_pkg::*; #(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         accept,
    input  logic [7:0]   byte_data,
    output logic [N-1:0] word,
    output logic         word_full
);

    localparam int BPW = bytes_per_word(N);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  word_q, word_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        word_full = accept && (cnt_q == CW'(BPW - 1));
        cnt_d     = accept ? (word_full ? '0 : cnt_q + 1'b1) : cnt_q;
        word_d    = word_q;
        if (accept) word_d[8*cnt_q +: 8] = byte_data;
    end

    assign word = word_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: shares the instruction-memory port between fetch and a byte-stream loader.
// A load stalls the CPU, zero-fills the whole memory, then writes the streamed program.
module imem_load_ctrl import imem_ctrl_pkg::*; #(
    parameter int N  = WORD_W,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] fetch_addr,
    output logic [N-1:0]  fetch_q,
    input  logic          load_req,
    input  logic [AW:0]   load_len,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_q,
    output logic          cpu_stall,
    output logic          busy,
    output logic          load_done
);

    // One extra address bit so a full 64-word load ends at 64 instead of wrapping to 0.
    localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

    state_e      state_q, state_d;
    logic [AW:0] wr_addr_q, wr_addr_d, len_q, len_d;
    logic        load_done_q, load_done_d;
    logic        run, accept, word_full;
    logic [N-1:0] word;

    byte_packer #(.N(N)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .accept    (accept),
        .byte_data (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wr_addr_q   <= '0;
            len_q       <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            len_q       <= len_d;
            load_done_q <= load_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        len_d       = len_q;
        load_done_d = 1'b0;
        case (state_q)
            RUN: if (load_req) begin
                state_d   = CLEAR;
                wr_addr_d = '0;
                len_d     = (load_len > DEPTH) ? DEPTH : load_len;
            end
            CLEAR: begin
                wr_addr_d = wr_addr_q + 1'b1;
                if (wr_addr_q == DEPTH - 1'b1) begin
                    wr_addr_d   = '0;
                    state_d     = (len_q != '0) ? LOAD : RUN;
                    load_done_d = (len_q == '0);
                end
            end
            LOAD: state_d = word_full ? WRITE : LOAD;
            WRITE: begin
                wr_addr_d   = wr_addr_q + 1'b1;
                state_d     = (wr_addr_d == len_q) ? RUN : LOAD;
                load_done_d = (wr_addr_d == len_q);
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        run        = (state_q == RUN);
        mem_addr   = run ? fetch_addr : wr_addr_q[AW-1:0];
        mem_we     = (state_q == CLEAR) || (state_q == WRITE);
        mem_wdata  = (state_q == WRITE) ? word : N'(NOP_INSN);
        fetch_q    = run ? mem_q : N'(NOP_INSN);
        byte_ready = (state_q == LOAD);
        accept     = byte_valid && byte_ready;
        cpu_stall  = !run;
        busy       = !run;
        load_done  = load_done_q;
    end

endmodule
